// File: rtl/bp_resolve_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_resolve_queue_pkg
// Brief    : Shared branch-predictor constants, PHT index width, counter codes
// Revision : 1.0
// ============================================================================
package bp_resolve_queue_pkg;

  localparam int PHT_ADDR_W = 10;

  // 2-bit saturating counter states of the pattern history table
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_ctr_e;

  localparam logic c_true     = 1'b1;
  localparam logic c_false    = 1'b0;
  localparam logic c_rst_lvl  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/bp_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : bp_fifo_mem
// Brief    : DEPTH x WIDTH register array, one write port, one async read port
// Revision : 1.0
// ============================================================================
module bp_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately unreset; occupancy is tracked by the owner.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/bp_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : bp_resolve_queue
// Brief    : In-order queue of in-flight branch predictions driving PHT updates
// Revision : 1.0
// ============================================================================
module bp_resolve_queue
  import bp_resolve_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = PHT_ADDR_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_valid,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       push_pred_dir,
  output logic                       push_ready,
  input  logic                       resolve_valid,
  input  logic                       resolve_dir,
  input  logic                       flush,
  output logic                       upd_valid,
  output logic [ADDR_W-1:0]          upd_addr,
  output logic                       upd_dir,
  output logic                       upd_mispredict,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [CNT_W-1:0]  r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_resolve;
  logic              w_mispredict;
  logic              w_kill;
  logic [ADDR_W:0]   w_head;
  logic              r_upd_valid;
  logic [ADDR_W-1:0] r_upd_addr;
  logic              r_upd_dir;
  logic              r_upd_mispredict;
  logic              r_err_underflow;

  assign w_full       = (r_count == c_depth);
  assign w_empty      = (r_count == '0);
  assign w_resolve    = resolve_valid && !w_empty;
  assign w_mispredict = (w_head[0] != resolve_dir);
  // A wrong-path kill and an external redirect both squash everything younger
  // than the resolving head, including a push arriving in the same cycle.
  assign w_kill       = flush || (w_resolve && w_mispredict);
  assign w_push       = push_valid && !w_full && !w_kill;
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_resolve);

  bp_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + 1),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_ptr  (r_wr_ptr),
    .wr_data ({push_addr, push_pred_dir}),
    .rd_ptr  (r_rd_ptr),
    .rd_data (w_head)
  );

  always_ff @(posedge clk) begin
    if (resetn == c_rst_lvl) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_upd_valid      <= c_false;
      r_upd_addr       <= '0;
      r_upd_dir        <= c_false;
      r_upd_mispredict <= c_false;
      r_err_underflow  <= c_false;
    end else begin
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_upd_valid <= w_resolve;
      if (w_kill) begin
        r_wr_ptr <= w_rd_ptr_nxt;
        r_count  <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
        r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_resolve);
      end
      if (w_resolve) begin
        r_upd_addr       <= w_head[ADDR_W:1];
        r_upd_dir        <= resolve_dir;
        r_upd_mispredict <= w_mispredict;
      end
      if (resolve_valid && w_empty) begin
        r_err_underflow <= c_true;
      end
    end
  end

  assign push_ready     = !w_full;
  assign upd_valid      = r_upd_valid;
  assign upd_addr       = r_upd_addr;
  assign upd_dir        = r_upd_dir;
  assign upd_mispredict = r_upd_mispredict;
  assign count          = r_count;
  assign err_underflow  = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_bp_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_resolve_queue
// Brief    : Scoreboard bench for bp_resolve_queue (DEPTH=4, ADDR_W=10)
// Revision : 1.0
// ============================================================================
module tb_bp_resolve_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              push_valid = 1'b0;
  logic [ADDR_W-1:0] push_addr = '0;
  logic              push_pred_dir = 1'b0;
  logic              push_ready;
  logic              resolve_valid = 1'b0;
  logic              resolve_dir = 1'b0;
  logic              flush = 1'b0;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic              upd_dir;
  logic              upd_mispredict;
  logic [2:0]        count;
  logic              err_underflow;

  typedef struct { logic [ADDR_W-1:0] addr; logic pred; } ent_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic dir; logic mis; } upd_t;

  ent_t mq[$];
  upd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bp_resolve_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .push_valid     (push_valid),
    .push_addr      (push_addr),
    .push_pred_dir  (push_pred_dir),
    .push_ready     (push_ready),
    .resolve_valid  (resolve_valid),
    .resolve_dir    (resolve_dir),
    .flush          (flush),
    .upd_valid      (upd_valid),
    .upd_addr       (upd_addr),
    .upd_dir        (upd_dir),
    .upd_mispredict (upd_mispredict),
    .count          (count),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every update strobe must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (resetn === 1'b1 && upd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL upd_unexpected: got addr=%h dir=%b mis=%b, required no update",
                 upd_addr, upd_dir, upd_mispredict);
      end else begin
        upd_t e;
        e = exp_q.pop_front();
        if ({upd_addr, upd_dir, upd_mispredict} !== {e.addr, e.dir, e.mis}) begin
          errors++;
          $display("FAIL upd_data: got addr=%h dir=%b mis=%b, required addr=%h dir=%b mis=%b",
                   upd_addr, upd_dir, upd_mispredict, e.addr, e.dir, e.mis);
        end
      end
    end
  end

  // One clock of stimulus; the reference queue model is advanced alongside.
  task automatic step(input logic pv, input logic [ADDR_W-1:0] pa, input logic pd,
                      input logic rv, input logic rd, input logic fl);
    int   sz;
    logic pok, rok, mis, kill;
    ent_t h;
    @(negedge clk);
    push_valid = pv; push_addr = pa; push_pred_dir = pd;
    resolve_valid = rv; resolve_dir = rd; flush = fl;
    sz   = mq.size();
    pok  = pv && (sz < DEPTH);
    rok  = rv && (sz > 0);
    mis  = 1'b0;
    if (rok) begin
      h   = mq.pop_front();
      mis = (h.pred != rd);
      exp_q.push_back('{h.addr, rd, mis});
    end
    kill = fl || (rok && mis);
    if (kill) mq.delete();
    else if (pok) mq.push_back('{pa, pd});
    @(posedge clk);
    #2;
    push_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push_valid = 1'($urandom); push_addr = 10'($urandom); push_pred_dir = 1'($urandom);
      resolve_valid = 1'($urandom); resolve_dir = 1'($urandom); flush = 1'($urandom);
      @(posedge clk);
      #2;
      checks++;
      if ({upd_valid, upd_addr, upd_dir, upd_mispredict, err_underflow} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got v=%b a=%h d=%b m=%b e=%b, required all 0",
                 upd_valid, upd_addr, upd_dir, upd_mispredict, err_underflow);
      end
      checks++;
      if (count !== 3'd0 || push_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_count: got count=%0d ready=%b, required count=0 ready=1", count, push_ready);
      end
    end
    @(negedge clk);
    push_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
    resetn = 1'b1;
    mq.delete(); exp_q.delete();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 10'h011 + 10'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (count !== 3'(i + 1)) begin
        errors++;
        $display("FAIL fill_count: got %0d, required %0d", count, i + 1);
      end
    end
    checks++;
    if (push_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b, required 0", push_ready);
    end
    step(1'b1, 10'h015, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL push_when_full: got count=%0d, required 4", count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (upd_valid !== 1'b1 || count !== 3'(DEPTH - 1 - i)) begin
        errors++;
        $display("FAIL drain: got upd_valid=%b count=%0d, required 1 and %0d", upd_valid, count, DEPTH - 1 - i);
      end
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (upd_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_done: got upd_valid=%b pending=%0d, required 0 and 0", upd_valid, exp_q.size());
    end
  endtask

  task automatic test_mispredict_kill();
    for (int i = 0; i < 3; i++) step(1'b1, 10'h031 + 10'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h040, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({upd_valid, upd_addr, upd_dir, upd_mispredict} !== {1'b1, 10'h031, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL kill_update: got v=%b a=%h d=%b m=%b, required v=1 a=031 d=0 m=1",
               upd_valid, upd_addr, upd_dir, upd_mispredict);
    end
    checks++;
    if (count !== 3'd0 || push_ready !== 1'b1) begin
      errors++;
      $display("FAIL kill_count: got count=%0d ready=%b, required 0 and 1", count, push_ready);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({upd_valid, upd_addr, upd_dir, upd_mispredict} !== {1'b0, 10'h031, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL upd_hold: got v=%b a=%h d=%b m=%b, required v=0 a=031 d=0 m=1",
               upd_valid, upd_addr, upd_dir, upd_mispredict);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 10'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      logic [ADDR_W-1:0] a;
      logic hp;
      a  = 10'h100 + 10'(i);
      hp = 1'((i - 1) & 1);
      step(1'b1, a, a[0], 1'b1, hp, 1'b0);
      checks++;
      if (count !== 3'd1 || upd_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_pair%0d: got count=%0d upd_valid=%b, required 1 and 1", i, count, upd_valid);
      end
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_end: got count=%0d pending=%0d, required 0 and 0", count, exp_q.size());
    end
  endtask

  task automatic test_flush_resolve();
    step(1'b1, 10'h020, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h021, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h022, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({upd_valid, upd_addr, upd_mispredict} !== {1'b1, 10'h020, 1'b0} || count !== 3'd0) begin
      errors++;
      $display("FAIL flush_resolve: got v=%b a=%h m=%b count=%0d, required v=1 a=020 m=0 count=0",
               upd_valid, upd_addr, upd_mispredict, count);
    end
    step(1'b1, 10'h023, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (count !== 3'd0 || push_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_push: got count=%0d ready=%b, required 0 and 1", count, push_ready);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (upd_valid !== 1'b0 || err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow: got upd_valid=%b err=%b, required 0 and 1", upd_valid, err_underflow);
    end
    step(1'b1, 10'h055, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (err_underflow !== 1'b1 || upd_valid !== 1'b1) begin
      errors++;
      $display("FAIL underflow_sticky: got err=%b upd_valid=%b, required 1 and 1", err_underflow, upd_valid);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 10'h061, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h062, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b0; resolve_valid = 1'b1; resolve_dir = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (count !== 3'd0 || upd_valid !== 1'b0 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got count=%0d upd_valid=%b err=%b, required 0 0 0", count, upd_valid, err_underflow);
    end
    @(negedge clk);
    resetn = 1'b1; resolve_valid = 1'b0;
    mq.delete(); exp_q.delete();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd0 || upd_valid !== 1'b0 || push_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after: got count=%0d upd_valid=%b ready=%b, required 0 0 1", count, upd_valid, push_ready);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_mispredict_kill();
    test_wrap();
    test_flush_resolve();
    test_underflow();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bp_resolve_queue.md
Name: bp_resolve_queue

Overview:
- In-order queue of in-flight conditional-branch predictions, sitting between the fetch-stage predictor and the execute-stage branch resolver.
- Fetch pushes the PHT index and the predicted direction for each branch. The resolver pops the head entry together with the actual direction.
- The block issues a registered PHT update (index, taken) and a mispredict indication. On a mispredict it discards all younger wrong-path entries.
- It is the update-side driver of the pattern history table.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- ADDR_W, 10, PHT index width; must match the shared predictor package.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- push_valid  in  1  fetch offers a predicted branch this cycle
- push_addr  in  ADDR_W  PHT index used for the prediction
- push_pred_dir  in  1  predicted direction (1 = taken)
- push_ready  out  1  queue can accept a push this cycle; equals !full, derived from registered state only
- resolve_valid  in  1  resolver reports the oldest outstanding branch
- resolve_dir  in  1  actual direction (1 = taken)
- flush  in  1  external redirect (exception/eret); discard all entries
- upd_valid  out  1  PHT update strobe
- upd_addr  out  ADDR_W  PHT index to update
- upd_dir  out  1  actual direction for the 2-bit counter
- upd_mispredict  out  1  head prediction differed from resolve_dir
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- err_underflow  out  1  sticky: resolve_valid seen while empty

Behaviour:
- Storage: DEPTH x {addr, pred_dir}. Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count is kept explicitly.
- full = (count == DEPTH); empty = (count == 0).
- Reset (resetn low at a clk edge): pointers = 0, count = 0, upd_valid = 0, upd_addr = 0, upd_dir = 0, upd_mispredict = 0, err_underflow = 0. Entry storage is not reset.
- Reset held over several cycles keeps every output at its reset value.
- Reset asserted mid-operation drops all entries. No update is emitted for them.
- Push: accepted when push_valid && push_ready and no kill condition (see below) applies. The entry is written at the write pointer, which then increments.
- Resolve: accepted when resolve_valid && !empty. The head entry is read, and the read pointer increments.
- Update latency is 1 cycle. In the cycle after an accepted resolve:
  - upd_valid = 1
  - upd_addr = head.addr
  - upd_dir = resolve_dir
  - upd_mispredict = (head.pred_dir != resolve_dir)
- In every other cycle upd_valid = 0; upd_addr, upd_dir and upd_mispredict hold their last values.
- Mispredict kill: when an accepted resolve mispredicts, all entries younger than the head are discarded in the same edge. A push in that same cycle is also discarded.
  - Result: count = 0, write pointer = new read pointer.
- flush:
  - Discards every entry and any push in the same cycle.
  - Result: count = 0, write pointer = read pointer.
  - A resolve in the same cycle is still accepted and its update is still emitted, because that branch is older than the redirect. Its mispredict flag is reported normally.
- Push and correct resolve in the same cycle: both are accepted and count is unchanged. This is legal when full only if push_ready was already high, i.e. it never is.
- resolve_valid while empty: ignored, no update, err_underflow is set and held until reset.
- push_valid while full: ignored. The producer must hold the branch.
- Priority per edge: reset > flush / mispredict kill > normal push / pop.
- No combinational path from any input to any output.

Decomposition:
- Shared predictor package holds:
  - PHT index width
  - 2-bit counter encodings SNT/WNT/WT/ST
  - True/false and reset-level constants
- One natural sub-module: bp_fifo_mem, the DEPTH x (ADDR_W+1) register array with one write port and one read port.
- Pointer and count logic and the kill logic stay in bp_resolve_queue.

Test Plan:
- Reset: hold resetn low 3 cycles with random inputs -> all outputs 0, count = 0, push_ready = 1.
- Fill and drain (DEPTH = 4):
  - Push addr 0x011..0x014, pred all taken -> count = 4, push_ready = 0.
  - A fifth push is ignored.
  - Resolve taken 4 times -> upd_addr 0x011..0x014 in order, each one cycle after its resolve, upd_mispredict = 0, count ends at 0.
- Mispredict kill:
  - Push 3 entries with pred taken.
  - Resolve head not-taken, with a push in the same cycle -> next cycle upd_valid = 1, upd_dir = 0, upd_mispredict = 1, count = 0, push_ready = 1.
- Wrap-around: 10 interleaved push/resolve pairs with correct predictions -> count stays 1, addresses return in FIFO order across pointer wrap.
- Flush with resolve:
  - Push 2 entries (0x020 pred not-taken, 0x021).
  - Assert flush and a resolve not-taken together -> upd_addr = 0x020, upd_mispredict = 0, count = 0.
- Underflow: resolve_valid on an empty queue -> upd_valid stays 0 and err_underflow = 1 until resetn low.
